// File: rtl/master_wrapper_pkg.sv
// Shared AXI definitions for the core-to-AXI master bridge: bus widths,
// fixed single-beat burst encodings, response codes and the bridge FSM states.
package master_wrapper_pkg;

  localparam int AXI_ID_BITS    = 4;
  localparam int AXI_ADDR_BITS  = 32;
  localparam int AXI_DATA_BITS  = 32;
  localparam int AXI_STRB_BITS  = 4;
  localparam int AXI_LEN_BITS   = 4;
  localparam int AXI_SIZE_BITS  = 3;
  localparam int AXI_BURST_BITS = 2;
  localparam int AXI_RESP_BITS  = 2;

  localparam logic [AXI_LEN_BITS-1:0]   LEN_ONE    = 4'h0;
  localparam logic [AXI_SIZE_BITS-1:0]  SIZE_WORD  = 3'b010;
  localparam logic [AXI_BURST_BITS-1:0] BURST_INCR = 2'b01;
  localparam logic [AXI_RESP_BITS-1:0]  RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_WRITE,
    ST_WRESP
  } state_t;

  function automatic logic resp_is_err(input logic [AXI_RESP_BITS-1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/master_wrapper.sv
// Core memory port to AXI master bridge: one outstanding single-beat access,
// request latched in IDLE, stall released combinationally on the completing beat.
module master_wrapper
  import master_wrapper_pkg::*;
#(
  parameter logic [AXI_ID_BITS-1:0] MASTER_ID = 4'h0
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      core_req,
  input  logic                      core_write,
  input  logic [31:0]               core_addr,
  input  logic [31:0]               core_wdata,
  input  logic [3:0]                core_web,
  output logic [31:0]               core_rdata,
  output logic                      core_stall,
  output logic                      core_err,
  output logic [AXI_ID_BITS-1:0]    ARID,
  output logic [31:0]               ARADDR,
  output logic [3:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [AXI_ID_BITS-1:0]    RID,
  input  logic [31:0]               RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST,
  input  logic                      RVALID,
  output logic                      RREADY,
  output logic [AXI_ID_BITS-1:0]    AWID,
  output logic [31:0]               AWADDR,
  output logic [3:0]                AWLEN,
  output logic [2:0]                AWSIZE,
  output logic [1:0]                AWBURST,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [31:0]               WDATA,
  output logic [3:0]                WSTRB,
  output logic                      WLAST,
  output logic                      WVALID,
  input  logic                      WREADY,
  input  logic [AXI_ID_BITS-1:0]    BID,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_web;
  logic [31:0] r_rdata;
  logic        r_aw_done;
  logic        r_w_done;
  logic        w_aw_done_nxt;
  logic        w_w_done_nxt;
  logic        w_both_done;
  logic        w_r_done;
  logic        w_b_done;
  logic        w_accept;

  // Only one transaction is ever in flight, so response IDs carry no information.
  logic w_unused_ids;
  assign w_unused_ids = ^{RID, BID};

  assign w_accept      = (r_state == ST_IDLE) & core_req;
  assign w_r_done      = (r_state == ST_RDATA) & RVALID & RLAST;
  assign w_b_done      = (r_state == ST_WRESP) & BVALID;
  // Valids are !done while in WRITE, so a ready there is a handshake.
  assign w_aw_done_nxt = r_aw_done | ((r_state == ST_WRITE) & AWREADY);
  assign w_w_done_nxt  = r_w_done  | ((r_state == ST_WRITE) & WREADY);
  assign w_both_done   = w_aw_done_nxt & w_w_done_nxt;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ARVALID     = 1'b0;
    RREADY      = 1'b0;
    AWVALID     = 1'b0;
    WVALID      = 1'b0;
    BREADY      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (core_req) w_state_nxt = core_write ? ST_WRITE : ST_RADDR;
      end
      ST_RADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) w_state_nxt = ST_RDATA;
      end
      ST_RDATA: begin
        RREADY = 1'b1;
        if (RVALID && RLAST) w_state_nxt = ST_IDLE;
      end
      ST_WRITE: begin
        AWVALID = !r_aw_done;
        WVALID  = !r_w_done;
        if (w_both_done) w_state_nxt = ST_WRESP;
      end
      ST_WRESP: begin
        BREADY = 1'b1;
        if (BVALID) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if ((r_state == ST_WRITE) && !w_both_done) begin
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end else begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_web   <= '0;
    end else if (w_accept) begin
      r_addr  <= core_addr;
      r_wdata <= core_wdata;
      r_web   <= core_web;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rdata <= '0;
    end else if (w_r_done) begin
      r_rdata <= RDATA;
    end
  end

  // The core sees read data and the release of stall in the same cycle as the final beat.
  assign core_rdata = w_r_done ? RDATA : r_rdata;
  assign core_stall = (r_state == ST_IDLE) ? core_req : !(w_r_done | w_b_done);
  assign core_err   = (w_r_done & resp_is_err(RRESP)) | (w_b_done & resp_is_err(BRESP));

  assign ARID    = MASTER_ID;
  assign ARADDR  = r_addr;
  assign ARLEN   = LEN_ONE;
  assign ARSIZE  = SIZE_WORD;
  assign ARBURST = BURST_INCR;

  assign AWID    = MASTER_ID;
  assign AWADDR  = r_addr;
  assign AWLEN   = LEN_ONE;
  assign AWSIZE  = SIZE_WORD;
  assign AWBURST = BURST_INCR;

  assign WDATA   = r_wdata;
  assign WSTRB   = r_web;
  assign WLAST   = 1'b1;

endmodule

// File: tb/tb_master_wrapper.sv
// Scoreboard bench for master_wrapper: a core driver and a randomised AXI slave push
// expectations; a negedge monitor pops and compares on every handshake and completion.
module tb_master_wrapper;
  import master_wrapper_pkg::*;

  localparam logic [3:0] MID = 4'hA;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic core_req = 1'b0, core_write = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic [3:0] core_web = '0;
  logic [31:0] core_rdata;
  logic core_stall, core_err;
  logic [3:0] ARID, AWID, RID = '0, BID = '0;
  logic [31:0] ARADDR, AWADDR, WDATA;
  logic [31:0] RDATA = '0;
  logic [3:0] ARLEN, AWLEN, WSTRB;
  logic [2:0] ARSIZE, AWSIZE;
  logic [1:0] ARBURST, AWBURST;
  logic [1:0] RRESP = '0, BRESP = '0;
  logic ARVALID, AWVALID, WVALID, WLAST, RREADY, BREADY;
  logic ARREADY = 1'b0, AWREADY = 1'b0, WREADY = 1'b0;
  logic RVALID = 1'b0, RLAST = 1'b0, BVALID = 1'b0;

  master_wrapper #(.MASTER_ID(MID)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .core_req(core_req), .core_write(core_write), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_web(core_web), .core_rdata(core_rdata),
    .core_stall(core_stall), .core_err(core_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb;
    logic [31:0] rdata; logic [1:0] resp; int d_a; int d_w; int d_r; int extra;
  } txn_t;
  typedef struct { logic wr; logic [31:0] rdata; logic err; } done_t;

  txn_t        slv_q[$];
  logic [31:0] exp_ar_q[$];
  logic [31:0] exp_aw_q[$];
  logic [35:0] exp_w_q[$];
  done_t       exp_done_q[$];

  int checks = 0;
  int errors = 0;
  bit slave_en = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [31:0] rdata, input logic [1:0] resp,
                              input int d_a, input int d_w, input int d_r, input int extra);
    txn_t t;
    t.wr = wr; t.addr = addr; t.wdata = wdata; t.strb = strb; t.rdata = rdata; t.resp = resp;
    t.d_a = d_a; t.d_w = d_w; t.d_r = d_r; t.extra = extra;
    return t;
  endfunction

  // Core side: issue one request and hold it until the stall-free cycle.
  task automatic run_txn(input txn_t t);
    int n;
    done_t d;
    if (t.wr) begin
      exp_aw_q.push_back(t.addr);
      exp_w_q.push_back({t.strb, t.wdata});
    end else begin
      exp_ar_q.push_back(t.addr);
    end
    d.wr = t.wr; d.rdata = t.rdata; d.err = (t.resp != RESP_OKAY);
    exp_done_q.push_back(d);
    slv_q.push_back(t);
    core_req = 1'b1; core_write = t.wr; core_addr = t.addr;
    core_wdata = t.wdata; core_web = t.strb;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (core_stall && n < 400);
    chk("txn_complete_in_budget", core_stall, 1'b0);
    @(posedge ACLK); #1;
  endtask

  task automatic idle(input int n);
    core_req = 1'b0;
    repeat (n) begin @(posedge ACLK); #1; end
  endtask

  // AXI slave: timing and response content come from the transaction record.
  initial begin
    txn_t t;
    int mx;
    forever begin
      @(posedge ACLK); #1;
      if (slave_en && ARESETn && (ARVALID || AWVALID) && slv_q.size() > 0) begin
        t = slv_q.pop_front();
        if (ARVALID) begin
          repeat (t.d_a) begin @(posedge ACLK); #1; end
          ARREADY = 1'b1;
          @(posedge ACLK); #1;
          ARREADY = 1'b0;
          repeat (t.d_r) begin @(posedge ACLK); #1; end
          for (int i = 0; i < t.extra; i++) begin
            RVALID = 1'b1; RLAST = 1'b0; RDATA = $urandom; RRESP = 2'($urandom_range(0, 3));
            @(posedge ACLK); #1;
          end
          RVALID = 1'b1; RLAST = 1'b1; RDATA = t.rdata; RRESP = t.resp;
          @(posedge ACLK); #1;
          RVALID = 1'b0; RLAST = 1'b0;
        end else begin
          mx = (t.d_a > t.d_w) ? t.d_a : t.d_w;
          for (int k = 0; k <= mx; k++) begin
            AWREADY = (k == t.d_a); WREADY = (k == t.d_w);
            @(posedge ACLK); #1;
          end
          AWREADY = 1'b0; WREADY = 1'b0;
          repeat (t.d_r) begin @(posedge ACLK); #1; end
          BVALID = 1'b1; BRESP = t.resp;
          @(posedge ACLK); #1;
          BVALID = 1'b0;
        end
      end
    end
  end

  // Monitor: protocol rules and scoreboard pops, sampled mid-cycle.
  logic p_ar_wait, p_aw_wait, p_w_wait, p_ar_hs, p_aw_hs, p_w_hs, p_done;
  logic [31:0] p_araddr, p_awaddr, p_wdata;
  logic [3:0] p_wstrb;
  logic aw_seen, w_seen;

  always @(negedge ACLK) begin
    logic [31:0] ea;
    logic [35:0] ew;
    done_t ed;
    if (!ARESETn) begin
      p_ar_wait = 0; p_aw_wait = 0; p_w_wait = 0; p_ar_hs = 0; p_aw_hs = 0; p_w_hs = 0;
      p_done = 0; aw_seen = 0; w_seen = 0;
    end else begin
      chk("no_read_write_overlap", ARVALID && (AWVALID || WVALID), 1'b0);
      if (p_ar_wait) begin chk("arvalid_hold", ARVALID, 1'b1); chk("araddr_stable", ARADDR, p_araddr); end
      if (p_aw_wait) begin chk("awvalid_hold", AWVALID, 1'b1); chk("awaddr_stable", AWADDR, p_awaddr); end
      if (p_w_wait) begin
        chk("wvalid_hold", WVALID, 1'b1);
        chk("w_stable", {WSTRB, WDATA}, {p_wstrb, p_wdata});
      end
      if (p_ar_hs) chk("arvalid_drop", ARVALID, 1'b0);
      if (p_aw_hs) chk("awvalid_drop", AWVALID, 1'b0);
      if (p_w_hs)  chk("wvalid_drop", WVALID, 1'b0);
      if (p_done)  chk("gap_after_completion", {ARVALID, AWVALID, WVALID}, 3'b000);
      if (ARVALID && ARREADY) begin
        if (exp_ar_q.size() == 0) chk("ar_expected", 1'b0, 1'b1);
        else begin
          ea = exp_ar_q.pop_front();
          chk("araddr", ARADDR, ea);
          chk("ar_attrs", {ARID, ARLEN, ARSIZE, ARBURST}, {MID, LEN_ONE, SIZE_WORD, BURST_INCR});
        end
      end
      if (AWVALID && AWREADY) begin
        if (exp_aw_q.size() == 0) chk("aw_expected", 1'b0, 1'b1);
        else begin
          ea = exp_aw_q.pop_front();
          chk("awaddr", AWADDR, ea);
          chk("aw_attrs", {AWID, AWLEN, AWSIZE, AWBURST}, {MID, LEN_ONE, SIZE_WORD, BURST_INCR});
        end
      end
      if (WVALID && WREADY) begin
        if (exp_w_q.size() == 0) chk("w_expected", 1'b0, 1'b1);
        else begin
          ew = exp_w_q.pop_front();
          chk("wdata_wstrb", {WSTRB, WDATA}, ew);
          chk("wlast", WLAST, 1'b1);
        end
      end
      if (BREADY) chk("bready_after_both", aw_seen && w_seen, 1'b1);
      if (AWVALID && AWREADY) aw_seen = 1;
      if (WVALID && WREADY) w_seen = 1;
      if (BVALID && BREADY) begin aw_seen = 0; w_seen = 0; end
      if (core_req && !core_stall) begin
        if (exp_done_q.size() == 0) chk("completion_expected", 1'b0, 1'b1);
        else begin
          ed = exp_done_q.pop_front();
          if (!ed.wr) chk("core_rdata", core_rdata, ed.rdata);
          chk("core_err", core_err, ed.err);
        end
      end else begin
        chk("core_err_quiet", core_err, 1'b0);
      end
      p_ar_wait = ARVALID && !ARREADY; p_araddr = ARADDR;
      p_aw_wait = AWVALID && !AWREADY; p_awaddr = AWADDR;
      p_w_wait  = WVALID && !WREADY;   p_wdata = WDATA; p_wstrb = WSTRB;
      p_ar_hs = ARVALID && ARREADY; p_aw_hs = AWVALID && AWREADY; p_w_hs = WVALID && WREADY;
      p_done = core_req && !core_stall;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    txn_t t;
    int n;
    #1;
    chk("reset_valids", {ARVALID, AWVALID, WVALID, RREADY, BREADY}, 5'b0);
    chk("reset_core", {core_rdata, core_err, core_stall}, 34'b0);
    repeat (3) @(negedge ACLK);
    #2 ARESETn = 1'b1;
    @(posedge ACLK); #1;

    run_txn(mk(0, 32'h0000_0040, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 3, 0, 0, 0));
    idle(2);
    run_txn(mk(1, 32'h0000_0010, 32'h1234_5678, 4'b0000, 32'h0, 2'b00, 2, 0, 1, 0));
    idle(2);
    run_txn(mk(1, 32'h0000_0020, 32'hA5A5_0F0F, 4'hF, 32'h0, 2'b10, 0, 0, 0, 0));
    idle(1);
    run_txn(mk(0, 32'h0000_0080, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00, 1, 0, 1, 1));
    run_txn(mk(1, 32'h0000_0084, 32'h7654_3210, 4'b0011, 32'h0, 2'b00, 1, 1, 0, 0));
    idle(2);

    for (int i = 0; i < 150; i++) begin
      t = mk(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)),
             $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 2));
      run_txn(t);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 2));
    end
    idle(2);

    // Abort a write while it waits for its response.
    slave_en = 1'b0;
    core_req = 1'b1; core_write = 1'b1; core_addr = 32'h0000_0100;
    core_wdata = 32'hCAFE_F00D; core_web = 4'hF;
    exp_aw_q.push_back(32'h0000_0100);
    exp_w_q.push_back({4'hF, 32'hCAFE_F00D});
    n = 0;
    do begin @(posedge ACLK); #1; n++; end while (!AWVALID && n < 10);
    chk("abort_write_awvalid", AWVALID, 1'b1);
    AWREADY = 1'b1; WREADY = 1'b1;
    @(posedge ACLK); #1;
    AWREADY = 1'b0; WREADY = 1'b0;
    @(negedge ACLK);
    chk("abort_in_wresp", BREADY, 1'b1);
    #2 ARESETn = 1'b0;
    #1;
    chk("async_reset_valids", {ARVALID, AWVALID, WVALID, RREADY, BREADY}, 5'b0);
    chk("async_reset_core", {core_rdata, core_err}, 33'b0);
    core_req = 1'b0;
    #1 chk("async_reset_stall", core_stall, 1'b0);
    repeat (2) @(negedge ACLK);
    #2 ARESETn = 1'b1;
    repeat (4) begin
      @(negedge ACLK);
      chk("no_reissue_after_reset", {ARVALID, AWVALID, WVALID, RREADY, BREADY}, 5'b0);
    end
    slave_en = 1'b1;
    @(posedge ACLK); #1;
    run_txn(mk(0, 32'h0000_0200, 32'h0, 4'h0, 32'h1357_9BDF, 2'b00, 0, 0, 0, 0));
    idle(4);

    chk("ar_queue_drained", exp_ar_q.size(), 0);
    chk("aw_queue_drained", exp_aw_q.size(), 0);
    chk("w_queue_drained", exp_w_q.size(), 0);
    chk("done_queue_drained", exp_done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
